ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_pkg.sv | 47 ++++
 rtl/ctrl_pipe_if.sv | 42 ++++
 rtl/ctrl_stage_reg.sv | 66 ++++++
 rtl/ctrl_pipe.sv | 93 +++++++++
 tb/tb_ctrl_pipe.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the control pipeline and the decoder:
//   - stage-index constants (E, M, W)
//   - bit offsets of fields inside the decoded control bundle
//   - the per-stage action encoding and the helper that resolves it
// No ports (package).
// -----------------------------------------------------------------------------
package ctrl_pipe_pkg;

    // Stage indices counted from the first stage after decode
    localparam int STG_E = 32'd0;
    localparam int STG_M = 32'd1;
    localparam int STG_W = 32'd2;

    // Control bundle layout; all *_WE bits must read 0 in a bubble
    localparam int CTL_RF_WE_BIT  = 32'd0;
    localparam int CTL_MEM_WE_BIT = 32'd1;
    localparam int CTL_CSR_WE_BIT = 32'd2;
    localparam int CTL_MEM_RE_BIT = 32'd3;
    localparam int CTL_ALU_OP_LSB = 32'd4;
    localparam int CTL_ALU_OP_W   = 32'd4;
    localparam int CTL_RD_LSB     = 32'd8;
    localparam int CTL_RD_W       = 32'd5;
    localparam int CTL_BUNDLE_W   = 32'd16;

    // What a stage register does on the next rising edge
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } stage_act_e;

    // Flush beats hold; without either the stage takes its upstream value
    function automatic stage_act_e stage_action(input logic flush, input logic hold);
        stage_act_e act;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (hold) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_if
// Bundle between the decode/hazard logic (master) and the control pipeline
// (slave).
//   ctrl_d/valid_d     : decoded bundle entering the pipe
//   stall/flush        : per-stage hold and bubble requests (bit 0 = E)
//   flush_all          : redirect/exception flush of every stage
//   ctrl_q/valid_q     : per-stage contents, stage i at [i*W +: W]
//   accept_d           : decode bundle consumed this cycle
//   retire_cnt         : saturating count of bundles leaving the last stage
//   bubble_cnt         : saturating count of cycles with an empty last stage
// -----------------------------------------------------------------------------
interface ctrl_pipe_if
    import ctrl_pipe_pkg::*;
#(
    parameter int W      = 16,
    parameter int STAGES = 3,
    parameter int CNTW   = 32
) ();

    logic [W-1:0]        ctrl_d;
    logic                valid_d;
    logic [STAGES-1:0]   stall;
    logic [STAGES-1:0]   flush;
    logic                flush_all;
    logic [STAGES*W-1:0] ctrl_q;
    logic [STAGES-1:0]   valid_q;
    logic                accept_d;
    logic [CNTW-1:0]     retire_cnt;
    logic [CNTW-1:0]     bubble_cnt;

    modport master (
        output ctrl_d, valid_d, stall, flush, flush_all,
        input  ctrl_q, valid_q, accept_d, retire_cnt, bubble_cnt
    );

    modport slave (
        input  ctrl_d, valid_d, stall, flush, flush_all,
        output ctrl_q, valid_q, accept_d, retire_cnt, bubble_cnt
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// -----------------------------------------------------------------------------
// ctrl_stage_reg
// One pipeline stage: W-bit control register plus valid bit.
//   clk, rst  : clock, synchronous active-high reset
//   i_flush   : load a bubble (ctrl=0, valid=0); overrides i_hold
//   i_hold    : keep current contents
//   i_ctrl    : bundle to load when neither flushed nor held
//   i_valid   : valid to load alongside i_ctrl
//   o_ctrl    : registered bundle
//   o_valid   : registered valid
// -----------------------------------------------------------------------------
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_hold,
    input  logic [W-1:0] i_ctrl,
    input  logic         i_valid,
    output logic [W-1:0] o_ctrl,
    output logic         o_valid
);

    logic [W-1:0] r_ctrl;
    logic         r_valid;
    stage_act_e   w_act;

    // Resolve flush/hold priority into a single action
    always_comb begin
        w_act = stage_action(i_flush, i_hold);
    end

    // Stage register; unknown action falls back to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl  <= {W{1'b0}};
            r_valid <= 1'b0;
        end else begin
            case (w_act)
                ACT_LOAD: begin
                    r_ctrl  <= i_ctrl;
                    r_valid <= i_valid;
                end
                ACT_HOLD: begin
                    r_ctrl  <= r_ctrl;
                    r_valid <= r_valid;
                end
                ACT_FLUSH: begin
                    r_ctrl  <= {W{1'b0}};
                    r_valid <= 1'b0;
                end
                default: begin
                    r_ctrl  <= {W{1'b0}};
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_valid = r_valid;

endmodule

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Control pipeline after decode: STAGES stage registers with backward-only
// stall propagation, per-stage and global flush, and saturating retire/bubble
// counters.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, beats every flush/stall
//   bus  : ctrl_pipe_if.slave (inputs ctrl_d/valid_d/stall/flush/flush_all,
//          outputs ctrl_q/valid_q/accept_d/retire_cnt/bubble_cnt)
// -----------------------------------------------------------------------------
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W      = 16,
    parameter int STAGES = 3,
    parameter int CNTW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    ctrl_pipe_if.slave    bus
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [STAGES-1:0] w_hold;
    logic [W-1:0]      w_stg_ctrl [STAGES];
    logic [STAGES-1:0] w_stg_valid;
    logic [W-1:0]      w_in_ctrl  [STAGES];
    logic [STAGES-1:0] w_in_valid;
    logic [CNTW-1:0]   r_retire_cnt;
    logic [CNTW-1:0]   r_bubble_cnt;

    // Effective hold: a stage is held if it or any downstream stage stalls
    always_comb begin
        w_hold = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            w_hold[i] = |(bus.stall >> i);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == STG_E) begin : g_first
            assign w_in_ctrl[g]  = bus.ctrl_d;
            assign w_in_valid[g] = bus.valid_d;
        end else begin : g_next
            // A free-running stage behind a held one must take a bubble,
            // otherwise the held bundle would be duplicated downstream
            assign w_in_ctrl[g]  = w_hold[g-1] ? {W{1'b0}} : w_stg_ctrl[g-1];
            assign w_in_valid[g] = w_hold[g-1] ? 1'b0      : w_stg_valid[g-1];
        end

        ctrl_stage_reg #(
            .W (W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_flush (bus.flush_all | bus.flush[g]),
            .i_hold  (w_hold[g]),
            .i_ctrl  (w_in_ctrl[g]),
            .i_valid (w_in_valid[g]),
            .o_ctrl  (w_stg_ctrl[g]),
            .o_valid (w_stg_valid[g])
        );

        assign bus.ctrl_q[g*W +: W] = w_stg_ctrl[g];
    end

    // Saturating retire and bubble counters observed at the last stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= {CNTW{1'b0}};
            r_bubble_cnt <= {CNTW{1'b0}};
        end else begin
            if (w_stg_valid[STAGES-1] && !w_hold[STAGES-1] && (r_retire_cnt != CNT_MAX)) begin
                r_retire_cnt <= r_retire_cnt + CNT_ONE;
            end else begin
                r_retire_cnt <= r_retire_cnt;
            end
            if (!w_stg_valid[STAGES-1] && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

    assign bus.valid_q    = w_stg_valid;
    assign bus.accept_d   = ~w_hold[0];
    assign bus.retire_cnt = r_retire_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed bench for ctrl_pipe. Two instances share one stimulus: a default
// CNTW=32 pipe and a CNTW=4 pipe whose counters must saturate at 0xF. Each
// stimulus step pushes the expected post-edge state into a queue; a monitor
// pops and compares once the DUT has updated.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;

    typedef struct packed {
        logic [47:0] ctrl;
        logic [2:0]  valid;
        logic        acc;
        logic [31:0] ret;
        logic [31:0] bub;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    ctrl_pipe_if #(.W(16), .STAGES(3), .CNTW(32)) bus   ();
    ctrl_pipe_if #(.W(16), .STAGES(3), .CNTW(4))  bus_s ();

    ctrl_pipe #(.W(16), .STAGES(3), .CNTW(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    ctrl_pipe #(.W(16), .STAGES(3), .CNTW(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    assign bus_s.ctrl_d    = bus.ctrl_d;
    assign bus_s.valid_d   = bus.valid_d;
    assign bus_s.stall     = bus.stall;
    assign bus_s.flush     = bus.flush;
    assign bus_s.flush_all = bus.flush_all;

    always #5 clk = ~clk;

    function automatic logic [63:0] sat4(input logic [31:0] x);
        return (x > 32'd15) ? 64'd15 : 64'(x);
    endfunction

    task automatic check(input string nm, input string what,
                         input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, req);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input string nm, input logic r,
                        input logic [15:0] cd, input logic vd,
                        input logic [2:0] st, input logic [2:0] fl, input logic fa,
                        input logic [47:0] ec, input logic [2:0] ev, input logic ea,
                        input int er, input int eb);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.ctrl_d    = cd;
        bus.valid_d   = vd;
        bus.stall     = st;
        bus.flush     = fl;
        bus.flush_all = fa;
        e.ctrl  = ec;
        e.valid = ev;
        e.acc   = ea;
        e.ret   = 32'(er);
        e.bub   = 32'(eb);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: sample accept_d mid-cycle, then compare state after the edge
    initial begin : monitor
        exp_t  e;
        string nm;
        logic  acc_s;
        forever begin
            @(negedge clk);
            #1;
            acc_s = bus.accept_d;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "ctrl_q",     64'(bus.ctrl_q),       64'(e.ctrl));
                check(nm, "valid_q",    64'(bus.valid_q),      64'(e.valid));
                check(nm, "accept_d",   64'(acc_s),            64'(e.acc));
                check(nm, "retire_cnt", 64'(bus.retire_cnt),   64'(e.ret));
                check(nm, "bubble_cnt", 64'(bus.bubble_cnt),   64'(e.bub));
                check(nm, "sat_retire", 64'(bus_s.retire_cnt), sat4(e.ret));
                check(nm, "sat_bubble", 64'(bus_s.bubble_cnt), sat4(e.bub));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        rst           = 1'b1;
        bus.ctrl_d    = 16'h0000;
        bus.valid_d   = 1'b0;
        bus.stall     = 3'b000;
        bus.flush     = 3'b000;
        bus.flush_all = 1'b0;

        //   name        rst   ctrl_d    vd    stall   flush   fa    {s2,s1,s0}                         valid   acc   ret bub
        step("rst",      1'b1, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h0000, 16'h0000}, 3'b000, 1'b1, 0, 0);
        step("flow0",    1'b0, 16'hA5A5, 1'b1, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h0000, 16'hA5A5}, 3'b001, 1'b1, 0, 1);
        step("flow1",    1'b0, 16'h1111, 1'b1, 3'b000, 3'b000, 1'b0, {16'h0000, 16'hA5A5, 16'h1111}, 3'b011, 1'b1, 0, 2);
        step("flow2",    1'b0, 16'h2222, 1'b1, 3'b000, 3'b000, 1'b0, {16'hA5A5, 16'h1111, 16'h2222}, 3'b111, 1'b1, 0, 3);
        step("flow3",    1'b0, 16'h3333, 1'b1, 3'b000, 3'b000, 1'b0, {16'h1111, 16'h2222, 16'h3333}, 3'b111, 1'b1, 1, 3);
        step("ldu",      1'b0, 16'h4444, 1'b1, 3'b001, 3'b000, 1'b0, {16'h2222, 16'h0000, 16'h3333}, 3'b101, 1'b0, 2, 3);
        step("ldu_rel",  1'b0, 16'h4444, 1'b1, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h3333, 16'h4444}, 3'b011, 1'b1, 3, 3);
        step("refill",   1'b0, 16'h5555, 1'b1, 3'b000, 3'b000, 1'b0, {16'h3333, 16'h4444, 16'h5555}, 3'b111, 1'b1, 3, 4);
        step("bp0",      1'b0, 16'h6666, 1'b1, 3'b100, 3'b000, 1'b0, {16'h3333, 16'h4444, 16'h5555}, 3'b111, 1'b0, 3, 4);
        step("bp1",      1'b0, 16'h6666, 1'b1, 3'b100, 3'b000, 1'b0, {16'h3333, 16'h4444, 16'h5555}, 3'b111, 1'b0, 3, 4);
        step("bp_rel",   1'b0, 16'h6666, 1'b1, 3'b000, 3'b000, 1'b0, {16'h4444, 16'h5555, 16'h6666}, 3'b111, 1'b1, 4, 4);
        step("fl_st1",   1'b0, 16'h7777, 1'b1, 3'b010, 3'b010, 1'b0, {16'h0000, 16'h0000, 16'h6666}, 3'b001, 1'b0, 5, 4);
        step("after_fl", 1'b0, 16'h7777, 1'b1, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h6666, 16'h7777}, 3'b011, 1'b1, 5, 5);
        step("fill",     1'b0, 16'h8888, 1'b1, 3'b000, 3'b000, 1'b0, {16'h6666, 16'h7777, 16'h8888}, 3'b111, 1'b1, 5, 6);
        step("flushall", 1'b0, 16'h9999, 1'b1, 3'b000, 3'b000, 1'b1, {16'h0000, 16'h0000, 16'h0000}, 3'b000, 1'b1, 6, 6);
        step("empty0",   1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h0000, 16'h0000}, 3'b000, 1'b1, 6, 7);
        step("empty1",   1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h0000, 16'h0000}, 3'b000, 1'b1, 6, 8);

        // Long stream: 17 more retires push the CNTW=4 counter past 0xF
        for (int k = 0; k < 20; k++) begin
            logic [15:0] dk;
            logic [15:0] dk1;
            logic [15:0] dk2;
            logic [2:0]  ev;
            int          er;
            int          eb;
            dk  = 16'h1000 + 16'(k);
            dk1 = (k >= 1) ? 16'h1000 + 16'(k - 1) : 16'h0000;
            dk2 = (k >= 2) ? 16'h1000 + 16'(k - 2) : 16'h0000;
            ev  = {(k >= 2), (k >= 1), 1'b1};
            er  = 6 + ((k >= 3) ? (k - 2) : 0);
            eb  = 8 + ((k < 3) ? (k + 1) : 3);
            step("stream", 1'b0, dk, 1'b1, 3'b000, 3'b000, 1'b0, {dk2, dk1, dk}, ev, 1'b1, er, eb);
        end

        step("rst_mid",  1'b1, 16'hAAAA, 1'b1, 3'b111, 3'b000, 1'b1, {16'h0000, 16'h0000, 16'h0000}, 3'b000, 1'b0, 0, 0);
        step("post_rst", 1'b0, 16'hCCCC, 1'b1, 3'b000, 3'b000, 1'b0, {16'h0000, 16'h0000, 16'hCCCC}, 3'b001, 1'b1, 0, 1);
        step("fl_st0",   1'b0, 16'hDDDD, 1'b1, 3'b001, 3'b001, 1'b0, {16'h0000, 16'h0000, 16'h0000}, 3'b000, 1'b0, 0, 2);

        repeat (2) @(negedge clk);
        check("end", "queue_left", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
